sram_arbiter: RTL

- Shares the single 8-bit external SRAM (21-bit address, async, active-low WE) between two requesters: the ioctl ROM/disk-image download stream and the system memory port.
- Generates SRAM address, data, output enable and WE_n timing from a multi-cycle access state machine.
- Applies ioctl_wait backpressure to the download source.
- Sits between next186 system logic and the SRAM pins in the top level.

---
 rtl/sram_arbiter.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 8-bit SRAM between the ioctl download
// stream and the CPU memory port. Every access runs IDLE -> SETUP -> PULSE -> HOLD,
// and all SRAM pins and status outputs come straight from registers.
module sram_arbiter #(
    parameter int unsigned ACC_CYCLES = 2,
    parameter logic [7:0]  ROM_INDEX  = 8'h00,
    parameter logic [20:0] LOAD_BASE  = 21'h000000
) (
    input  logic        clk_25,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        dl_overrun,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        busy,
    output logic [20:0] SRAM_A,
    output logic        SRAM_WE_n,
    output logic [7:0]  SRAM_DQ_O,
    output logic        SRAM_DQ_OE,
    input  logic [7:0]  SRAM_DQ_I
);

    localparam logic [3:0] LAST_CNT = 4'(ACC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    // Download holding register
    logic        r_dl_pending;
    logic [20:0] r_dl_addr;
    logic [7:0]  r_dl_data;
    logic        r_dl_overrun;
    logic        r_dl_prev;

    // Grant bookkeeping for the access in flight
    logic        r_grant_dl;
    logic        r_acc_we;
    logic        r_last_dl;

    // Registered outputs and their next values
    logic [20:0] r_sram_a,    w_sram_a_next;
    logic [7:0]  r_dq_o,      w_dq_o_next;
    logic        r_dq_oe,     w_dq_oe_next;
    logic        r_we_n,      w_we_n_next;
    logic [7:0]  r_cpu_rdata, w_cpu_rdata_next;
    logic        r_cpu_ack,   w_cpu_ack_next;
    logic        r_busy,      w_busy_next;

    logic        w_cpu_cand;
    logic        w_dl_cand;
    logic        w_grant_any;
    logic        w_grant_dl;
    logic        w_pulse_done;
    logic        w_capture;
    logic        w_dl_done;
    logic        w_dl_rise;
    logic [20:0] w_dl_addr_sum;
    logic        w_unused_addr;

    // Upper download address bits lie beyond the 2 MB SRAM and are ignored
    assign w_unused_addr = ^ioctl_addr[24:21];

    // The CPU is never a candidate in its own ack cycle, so a stale request
    // that is being dropped cannot start a second access.
    assign w_cpu_cand   = cpu_req & ~r_cpu_ack;
    assign w_dl_cand    = r_dl_pending;
    assign w_grant_any  = w_cpu_cand | w_dl_cand;
    // With both candidates, alternate away from whoever was served last
    assign w_grant_dl   = w_dl_cand & (~w_cpu_cand | ~r_last_dl);
    assign w_pulse_done = (r_cnt == LAST_CNT);

    assign w_capture     = ioctl_wr & ioctl_download & (ioctl_index == ROM_INDEX);
    assign w_dl_done     = (r_state == S_HOLD) & r_grant_dl;
    assign w_dl_rise     = ioctl_download & ~r_dl_prev;
    assign w_dl_addr_sum = ioctl_addr[20:0] + LOAD_BASE;

    // State register and PULSE-length counter
    always_ff @(posedge clk_25) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: fixed SETUP/HOLD, PULSE stretched to ACC_CYCLES
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_next = S_PULSE;
                w_cnt_next   = 4'd0;
            end
            S_PULSE: begin
                if (w_pulse_done) begin
                    w_state_next = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_HOLD: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: next values for every registered pin and status output
    always_comb begin
        w_sram_a_next    = r_sram_a;
        w_dq_o_next      = r_dq_o;
        w_dq_oe_next     = r_dq_oe;
        w_we_n_next      = 1'b1;
        w_cpu_rdata_next = r_cpu_rdata;
        w_cpu_ack_next   = 1'b0;
        w_busy_next      = (w_state_next != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_sram_a_next = w_grant_dl ? r_dl_addr : cpu_addr;
                    w_dq_o_next   = w_grant_dl ? r_dl_data : cpu_wdata;
                    w_dq_oe_next  = w_grant_dl | cpu_we;
                end
            end
            S_SETUP: begin
                w_we_n_next = ~r_acc_we;
            end
            S_PULSE: begin
                if (w_pulse_done) begin
                    // Data has settled for the whole pulse; sample it as we leave
                    if (!r_acc_we) begin
                        w_cpu_rdata_next = SRAM_DQ_I;
                    end
                end else begin
                    w_we_n_next = ~r_acc_we;
                end
            end
            S_HOLD: begin
                w_dq_oe_next   = 1'b0;
                w_cpu_ack_next = ~r_grant_dl;
            end
            default: begin
                w_dq_oe_next = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk_25) begin
        if (reset) begin
            r_sram_a    <= 21'd0;
            r_dq_o      <= 8'd0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_cpu_rdata <= 8'd0;
            r_cpu_ack   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sram_a    <= w_sram_a_next;
            r_dq_o      <= w_dq_o_next;
            r_dq_oe     <= w_dq_oe_next;
            r_we_n      <= w_we_n_next;
            r_cpu_rdata <= w_cpu_rdata_next;
            r_cpu_ack   <= w_cpu_ack_next;
            r_busy      <= w_busy_next;
        end
    end

    // Latch who was granted and the direction, for the rest of the access
    always_ff @(posedge clk_25) begin
        if (reset) begin
            r_grant_dl <= 1'b0;
            r_acc_we   <= 1'b0;
            r_last_dl  <= 1'b0;
        end else if ((r_state == S_IDLE) && w_grant_any) begin
            r_grant_dl <= w_grant_dl;
            r_acc_we   <= w_grant_dl | cpu_we;
            r_last_dl  <= w_grant_dl;
        end
    end

    // Download capture: one-byte buffer, overrun flag sticky until the next window
    always_ff @(posedge clk_25) begin
        if (reset) begin
            r_dl_pending <= 1'b0;
            r_dl_addr    <= 21'd0;
            r_dl_data    <= 8'd0;
            r_dl_overrun <= 1'b0;
            r_dl_prev    <= 1'b0;
        end else begin
            r_dl_prev <= ioctl_download;
            if (w_dl_rise) begin
                r_dl_overrun <= 1'b0;
            end
            // A byte arriving on the completion edge replaces the finished one
            if (w_capture && (!r_dl_pending || w_dl_done)) begin
                r_dl_pending <= 1'b1;
                r_dl_addr    <= w_dl_addr_sum;
                r_dl_data    <= ioctl_dout;
            end else if (w_capture) begin
                r_dl_overrun <= 1'b1;
            end else if (w_dl_done) begin
                r_dl_pending <= 1'b0;
            end
        end
    end

    assign ioctl_wait = r_dl_pending;
    assign dl_overrun = r_dl_overrun;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ack    = r_cpu_ack;
    assign busy       = r_busy;
    assign SRAM_A     = r_sram_a;
    assign SRAM_WE_n  = r_we_n;
    assign SRAM_DQ_O  = r_dq_o;
    assign SRAM_DQ_OE = r_dq_oe;

endmodule
